uart: RTL and testbench
=======================

Name: uart

Overview:
- Memory-mapped 8N1 serial UART for the system CSR bus.
- Contains a transmitter, a receiver with 16x oversampling, a programmable baud divisor, and a loopback ("thru") mode.
- The CPU configures the block and moves data through four 32-bit CSRs in a bank selected by csr_a[13:10].
- Raises single-cycle rx/tx event pulses toward the interrupt controller.

Parameters:
- csr_addr, 4'h0: CSR bank number. The block responds only when csr_a[13:10] == csr_addr.
- clk_freq, 100000000: sys_clk frequency in Hz.
- baud, 115200: reset baud rate. The reset divisor is clk_freq/(16*baud), truncated to 16 bits.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_rst  in  1  asynchronous, active-low reset.
- csr_a  in  14  CSR address; [13:10] selects the bank, [1:0] selects the register.
- csr_we  in  1  write strobe, sampled each cycle.
- csr_di  in  32  write data.
- csr_do  out  32  registered read data.
- rx_irq  out  1  one-cycle pulse when a byte has been received.
- tx_irq  out  1  one-cycle pulse when a frame has been fully sent.
- uart_rx  in  1  serial input, asynchronous.
- uart_tx  out  1  serial output; idles high.

Behaviour:
- Reset values (sys_rst low): csr_do=0, rx_irq=0, tx_irq=0, uart_tx=1, divisor=clk_freq/(16*baud), thru=0, rx_data=0, tx_busy=0, both FSMs idle, counters cleared. Reset asserted mid-frame aborts the frame immediately.
- sel = (csr_a[13:10]==csr_addr).
- Register map by csr_a[1:0]:
  - 0 RXTX: write starts a transmission of csr_di[7:0]; read returns {24'b0, rx_data}.
  - 1 DIVISOR: [15:0] read/write.
  - 2 CTRL: [0] thru, read/write.
  - 3 STAT: read-only {31'b0, tx_busy}; writes are ignored.
- Reads: csr_do is updated every cycle from the address in the previous cycle, giving 1-cycle latency. csr_do=0 when not selected.
- Writes take effect at the clock edge where csr_we & sel.
- Baud tick: a 16-bit down-counter reloads with (divisor-1) and emits tick16 when it reaches 0. This gives one tick per divisor cycles; divisor 0 is treated as 1. Writing DIVISOR reloads the counter.
- TX FSM states IDLE, START, DATA, STOP. Each bit lasts 16 tick16 periods.
  - IDLE->START on a RXTX write while tx_busy=0. Latch csr_di[7:0] and set tx_busy=1.
  - A RXTX write while tx_busy=1 is ignored.
  - Frame order: start bit 0, then data bits LSB first, then stop bit 1.
  - At the end of the stop bit: tx_irq pulses for 1 cycle, tx_busy=0, return to IDLE.
- RX path:
  - uart_rx passes through a 2-flop synchronizer.
  - In IDLE, a synchronized falling edge starts the tick count.
  - At 8 ticks (mid start bit) the line is rechecked. If high, the start is a glitch: return to IDLE with no irq.
  - Each data bit is then sampled every 16 ticks, LSB first, then the stop bit.
  - Stop bit 1: rx_data is updated and rx_irq pulses for 1 cycle.
  - Stop bit 0 (framing error): the byte is discarded, no irq, wait for the line to return high before returning to IDLE.
  - rx_data holds its value until the next good frame.
- thru=1: uart_tx = synchronized uart_rx, combinational after the synchronizer. The TX FSM still runs and still pulses tx_irq, but its serial output is hidden.
- Simultaneous RX completion and RXTX read: the read returns the old rx_data; the new value is visible from the next read.

Test Plan:
- Reset: hold sys_rst low 2 cycles, then release.
  - Required: uart_tx=1, rx_irq=tx_irq=0.
  - Read DIVISOR with clk_freq=500000000, baud=9600 -> 3255 (0x0CB7).
- Divisor R/W: write DIVISOR=1, read back -> csr_do=0x00000001 one cycle after the address is presented. Read with csr_a[13:10]≠csr_addr -> 0.
- TX 0x4A with divisor=1: write RXTX=0x4A.
  - Required: uart_tx sequence, 16 cycles per bit, is 0, 0,1,0,1,0,0,1,0, 1.
  - tx_busy=1 during the frame.
  - tx_irq pulses once, about 160 cycles after the write.
- RX, divisor=1: drive 0xA5 on uart_rx as an 8N1 frame with 16-cycle bits.
  - Required: one rx_irq pulse during the stop bit; RXTX reads 0x000000A5.
  - Repeat with stop bit 0 -> no rx_irq, rx_data stays 0xA5.
- Glitch and busy write:
  - An 4-cycle low pulse on uart_rx -> no rx_irq.
  - Write RXTX=0x55 during an ongoing TX frame -> ignored; the frame completes with the original byte.
- Thru: write CTRL=1, toggle uart_rx -> uart_tx follows after 2 cycles. Write CTRL=0 -> uart_tx=1 when TX is idle.

Source files
------------

// File: rtl/uart.sv
// 8N1 serial UART on the CSR bus: transmitter, 16x-oversampling receiver,
// programmable baud divisor and a loopback ("thru") mode.
module uart #(
    parameter logic [3:0]  csr_addr = 4'h0,
    parameter int unsigned clk_freq = 100000000,
    parameter int unsigned baud     = 115200
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    output logic        rx_irq,
    output logic        tx_irq,
    input  logic        uart_rx,
    output logic        uart_tx
);

    localparam int unsigned div_full  = clk_freq / (16 * baud);
    localparam logic [15:0] div_reset = div_full[15:0];

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    // ---------------- CSR decode ----------------
    logic        sel;
    logic        wr_rxtx;
    logic        wr_div;
    logic        wr_ctrl;
    logic [15:0] divisor;
    logic        thru;
    logic [31:0] rd_data;
    logic        unused_bits;

    assign sel     = (csr_a[13:10] == csr_addr);
    assign wr_rxtx = sel & csr_we & (csr_a[1:0] == 2'd0);
    assign wr_div  = sel & csr_we & (csr_a[1:0] == 2'd1);
    assign wr_ctrl = sel & csr_we & (csr_a[1:0] == 2'd2);

    // Address bits between the bank field and the register field are don't-care.
    assign unused_bits = ^{csr_a[9:2], csr_di[31:16]};

    // Configuration registers: divisor and loopback enable.
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            divisor <= div_reset;
            thru    <= 1'b0;
        end else begin
            if (wr_div)  divisor <= csr_di[15:0];
            if (wr_ctrl) thru    <= csr_di[0];
        end
    end

    // ---------------- Baud tick ----------------
    logic [15:0] baud_cnt;
    logic [15:0] div_m1;
    logic [15:0] new_div_m1;
    logic        tick16;

    // A divisor of 0 behaves like 1, i.e. a tick every cycle.
    assign div_m1     = (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;
    assign new_div_m1 = (csr_di[15:0] == 16'd0) ? 16'd0 : csr_di[15:0] - 16'd1;
    assign tick16     = (baud_cnt == 16'd0);

    // Down-counter producing one tick16 every divisor cycles; reloaded on a divisor write.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst)          baud_cnt <= 16'd0;
        else if (wr_div)       baud_cnt <= new_div_m1;
        else if (tick16)       baud_cnt <= div_m1;
        else                   baud_cnt <= baud_cnt - 16'd1;
    end

    // ---------------- Transmitter ----------------
    tx_state_t   tx_state, tx_state_n;
    logic [3:0]  tx_tick, tx_tick_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        tx_done;
    logic        tx_busy;
    logic        tx_line;

    assign tx_busy = (tx_state != TX_IDLE);

    // TX state and datapath registers.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            tx_state <= TX_IDLE;
            tx_tick  <= 4'd0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'd0;
            tx_irq   <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_tick  <= tx_tick_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_irq   <= tx_done;
        end
    end

    // TX next state: each bit spans 16 ticks; writes while busy fall through unused.
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        tx_state_n = tx_state;
        tx_tick_n  = tx_tick;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_done    = 1'b0;
        if (tx_state == TX_IDLE) begin
            if (wr_rxtx) begin
                tx_state_n = TX_START;
                tx_shift_n = csr_di[7:0];
                tx_tick_n  = 4'd0;
                tx_bit_n   = 3'd0;
            end
        end else if (tick16) begin
            tx_tick_n = tx_tick + 4'd1;
            if (tx_tick == 4'd15) begin
                case (tx_state)
                    TX_START: tx_state_n = TX_DATA;
                    TX_DATA: begin
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                        if (tx_bit == 3'd7) tx_state_n = TX_STOP;
                        else                tx_bit_n   = tx_bit + 3'd1;
                    end
                    default: begin
                        tx_state_n = TX_IDLE;
                        tx_done    = 1'b1;
                    end
                endcase
            end
        end
    end

    // Serial level driven by the transmitter.
    always_comb begin
        tx_line = 1'b1;
        case (tx_state)
            TX_START: tx_line = 1'b0;
            TX_DATA:  tx_line = tx_shift[0];
            default:  tx_line = 1'b1;
        endcase
    end

    // ---------------- Receiver ----------------
    logic        rx_s1, rx_s2;
    rx_state_t   rx_state, rx_state_n;
    logic [3:0]  rx_tick, rx_tick_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic [7:0]  rx_data;
    logic        rx_good;

    // Two-flop synchronizer for the asynchronous serial input; idles high.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
        end
    end

    // RX state, datapath and received-byte holding register.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            rx_state <= RX_IDLE;
            rx_tick  <= 4'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
            rx_data  <= 8'd0;
            rx_irq   <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_tick  <= rx_tick_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            rx_irq   <= rx_good;
            if (rx_good) rx_data <= rx_shift;
        end
    end

    // RX next state: confirm start at mid-bit, then sample every 16 ticks.
    always_comb begin
        rx_state_n = rx_state;
        rx_tick_n  = rx_tick;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_good    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_s2) begin
                    rx_state_n = RX_START;
                    rx_tick_n  = 4'd0;
                end
            end
            RX_START: begin
                if (tick16) begin
                    if (rx_tick == 4'd7) begin
                        rx_tick_n = 4'd0;
                        rx_bit_n  = 3'd0;
                        rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tick_n = rx_tick + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick16) begin
                    rx_tick_n = rx_tick + 4'd1;
                    if (rx_tick == 4'd15) begin
                        rx_shift_n = {rx_s2, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                        else                rx_bit_n   = rx_bit + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (tick16) begin
                    rx_tick_n = rx_tick + 4'd1;
                    if (rx_tick == 4'd15) begin
                        if (rx_s2) begin
                            rx_state_n = RX_IDLE;
                            rx_good    = 1'b1;
                        end else begin
                            rx_state_n = RX_WAIT;
                        end
                    end
                end
            end
            RX_WAIT: begin
                if (rx_s2) rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // ---------------- Read path and serial output ----------------
    // Read mux for the currently presented register.
    always_comb begin
        rd_data = 32'd0;
        case (csr_a[1:0])
            2'd0:    rd_data = {24'd0, rx_data};
            2'd1:    rd_data = {16'd0, divisor};
            2'd2:    rd_data = {31'd0, thru};
            default: rd_data = {31'd0, tx_busy};
        endcase
    end

    // Registered read data, zero when the bank is not selected.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) csr_do <= 32'd0;
        else          csr_do <= sel ? rd_data : 32'd0;
    end

    assign uart_tx = thru ? rx_s2 : tx_line;

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for the uart block: CSR vector table, TX frame
// inspection, RX frames with an irq scoreboard, glitch and thru sequences.
module tb_uart;

    logic        sys_clk;
    logic        sys_rst;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic        rx_irq;
    logic        tx_irq;
    logic        uart_rx;
    logic        uart_tx;

    localparam logic [13:0] A_RXTX = 14'h0800;
    localparam logic [13:0] A_DIV  = 14'h0801;
    localparam logic [13:0] A_CTRL = 14'h0802;
    localparam logic [13:0] A_STAT = 14'h0803;
    localparam logic [13:0] A_OTHR = 14'h0C01;

    uart #(.csr_addr(4'h2), .clk_freq(500000000), .baud(9600)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .csr_a   (csr_a),
        .csr_we  (csr_we),
        .csr_di  (csr_di),
        .csr_do  (csr_do),
        .rx_irq  (rx_irq),
        .tx_irq  (tx_irq),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;

    int         rx_irq_cnt = 0;
    int         tx_irq_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] rx_last = 8'h00;
    logic       mon_en = 1'b0;

    typedef struct {
        logic        we;
        logic [13:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic csr_write(input logic [13:0] a, input logic [31:0] d);
        csr_a  = a;
        csr_di = d;
        csr_we = 1'b1;
        step();
        csr_we = 1'b0;
    endtask

    task automatic csr_read(input logic [13:0] a, output logic [31:0] d);
        csr_a  = a;
        csr_we = 1'b0;
        step();
        d = csr_do;
    endtask

    // Scoreboard side: pop an expected entry whenever the DUT raises an event.
    always @(negedge sys_clk) begin
        if (mon_en && rx_irq) begin
            rx_irq_cnt++;
            if (rx_q.size() == 0) check("rx_irq_unexpected", 32'd1, 32'd0);
            else                  rx_last = rx_q.pop_front();
        end
        if (mon_en && tx_irq) begin
            tx_irq_cnt++;
            if (tx_q.size() == 0) check("tx_irq_unexpected", 32'd1, 32'd0);
            else                  void'(tx_q.pop_front());
        end
    end

    // Send one byte and inspect every cycle of the serial frame.
    task automatic tx_frame(input logic [7:0] b, input logic busy_write);
        logic [9:0] frame;
        logic       bit_err;
        logic       early_irq;
        frame = {1'b1, b, 1'b0};
        bit_err = 1'b0;
        early_irq = 1'b0;
        tx_q.push_back(b);
        csr_write(A_RXTX, {24'd0, b});
        csr_a = A_STAT;
        for (int i = 0; i < 160; i++) begin
            if (uart_tx !== frame[i / 16]) bit_err = 1'b1;
            if (tx_irq) early_irq = 1'b1;
            if (i == 8) check("tx_busy_mid_frame", csr_do, 32'd1);
            if (busy_write && i == 40) begin
                csr_a = A_RXTX; csr_di = 32'h55; csr_we = 1'b1;
            end
            if (busy_write && i == 41) begin
                csr_we = 1'b0; csr_a = A_STAT;
            end
            if (i % 16 == 15) begin
                check($sformatf("tx_%02h_bit%0d", b, i / 16), {31'd0, bit_err}, 32'd0);
                bit_err = 1'b0;
            end
            step();
        end
        check("tx_no_early_irq", {31'd0, early_irq}, 32'd0);
        check("tx_irq_at_end", {31'd0, tx_irq}, 32'd1);
        check("tx_idle_level", {31'd0, uart_tx}, 32'd1);
        step();
        check("tx_irq_one_cycle", {31'd0, tx_irq}, 32'd0);
        check("tx_busy_cleared", csr_do, 32'd0);
    endtask

    // Drive one 8N1 frame with 16-cycle bits on uart_rx.
    task automatic rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        if (stop) rx_q.push_back(b);
        for (int k = 0; k < 10; k++) begin
            uart_rx = frame[k];
            repeat (16) step();
        end
        uart_rx = 1'b1;
        repeat (20) step();
    endtask

    initial begin
        logic [31:0] rd;
        int          cnt_before;

        vecs[0]  = '{1'b0, A_DIV,  32'h0,        32'h00000CB7};
        vecs[1]  = '{1'b0, A_CTRL, 32'h0,        32'h0};
        vecs[2]  = '{1'b0, A_STAT, 32'h0,        32'h0};
        vecs[3]  = '{1'b0, A_RXTX, 32'h0,        32'h0};
        vecs[4]  = '{1'b1, A_DIV,  32'h1,        32'h0};
        vecs[5]  = '{1'b0, A_DIV,  32'h0,        32'h1};
        vecs[6]  = '{1'b0, A_OTHR, 32'h0,        32'h0};
        vecs[7]  = '{1'b1, A_STAT, 32'hFFFFFFFF, 32'h0};
        vecs[8]  = '{1'b0, A_STAT, 32'h0,        32'h0};
        vecs[9]  = '{1'b1, A_DIV,  32'h00012345, 32'h0};
        vecs[10] = '{1'b0, A_DIV,  32'h0,        32'h2345};
        vecs[11] = '{1'b1, A_OTHR, 32'h7,        32'h0};
        vecs[12] = '{1'b0, A_DIV,  32'h0,        32'h2345};
        vecs[13] = '{1'b1, A_CTRL, 32'hFFFFFFFE, 32'h0};
        vecs[14] = '{1'b0, A_CTRL, 32'h0,        32'h0};
        vecs[15] = '{1'b1, A_DIV,  32'h1,        32'h0};
        vecs[16] = '{1'b0, A_DIV,  32'h0,        32'h1};

        sys_rst = 1'b0;
        csr_a   = 14'd0;
        csr_we  = 1'b0;
        csr_di  = 32'd0;
        uart_rx = 1'b1;
        step();
        step();
        check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_rx_irq",  {31'd0, rx_irq},  32'd0);
        check("rst_tx_irq",  {31'd0, tx_irq},  32'd0);
        check("rst_csr_do",  csr_do,           32'd0);
        sys_rst = 1'b1;
        mon_en  = 1'b1;
        step();

        // CSR vector table.
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].we) begin
                csr_write(vecs[i].addr, vecs[i].data);
            end else begin
                csr_read(vecs[i].addr, rd);
                check($sformatf("csr_vec%0d", i), rd, vecs[i].exp);
            end
        end

        // Transmit, then transmit again with a write attempted mid-frame.
        tx_frame(8'h4A, 1'b0);
        repeat (5) step();
        tx_frame(8'hC3, 1'b1);
        repeat (5) step();
        check("tx_irq_count", tx_irq_cnt, 32'd2);

        // Receive a good frame.
        cnt_before = rx_irq_cnt;
        rx_frame(8'hA5, 1'b1);
        check("rx_a5_irq_count", rx_irq_cnt, cnt_before + 1);
        csr_read(A_RXTX, rd);
        check("rx_a5_data", rd, {24'd0, rx_last});
        check("rx_a5_literal", rd, 32'h000000A5);

        // Framing error: byte discarded, no irq.
        cnt_before = rx_irq_cnt;
        rx_frame(8'h3C, 1'b0);
        check("rx_frame_err_no_irq", rx_irq_cnt, cnt_before);
        csr_read(A_RXTX, rd);
        check("rx_frame_err_hold", rd, 32'h000000A5);

        // Another good frame after the error recovers.
        cnt_before = rx_irq_cnt;
        rx_frame(8'h81, 1'b1);
        check("rx_81_irq_count", rx_irq_cnt, cnt_before + 1);
        csr_read(A_RXTX, rd);
        check("rx_81_data", rd, {24'd0, rx_last});

        // Short low glitch on the line is rejected.
        cnt_before = rx_irq_cnt;
        uart_rx = 1'b0;
        repeat (4) step();
        uart_rx = 1'b1;
        repeat (40) step();
        check("rx_glitch_no_irq", rx_irq_cnt, cnt_before);

        // Thru mode: uart_tx follows the synchronized input two cycles later.
        cnt_before = rx_irq_cnt;
        csr_write(A_CTRL, 32'd1);
        uart_rx = 1'b0;
        step();
        check("thru_lag1_high", {31'd0, uart_tx}, 32'd1);
        step();
        check("thru_follow_low", {31'd0, uart_tx}, 32'd0);
        uart_rx = 1'b1;
        step();
        check("thru_lag1_low", {31'd0, uart_tx}, 32'd0);
        step();
        check("thru_follow_high", {31'd0, uart_tx}, 32'd1);
        repeat (20) step();
        csr_write(A_CTRL, 32'd0);
        csr_read(A_CTRL, rd);
        check("thru_cleared", rd, 32'd0);
        uart_rx = 1'b0;
        repeat (3) step();
        check("thru_off_tx_idle", {31'd0, uart_tx}, 32'd1);
        uart_rx = 1'b1;
        repeat (30) step();
        check("thru_no_rx_irq", rx_irq_cnt, cnt_before);

        check("rx_queue_empty", rx_q.size(), 32'd0);
        check("tx_queue_empty", tx_q.size(), 32'd0);
        check("rx_irq_total", rx_irq_cnt, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
